// File: rtl/trigger_chain_wb_sequencer.sv
// Wishbone classic initiator that fans one command out to the selected
// trigger-chain channels, one single-beat bus cycle per channel in ascending
// order, returning a response per channel and a completion pulse per command.
module trigger_chain_wb_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [9:0]  cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,
    input  logic [7:0]  cmd_chmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [2:0]  rsp_chan_o,
    output logic [31:0] rsp_dat_o,
    output logic [1:0]  rsp_status_o,
    output logic        done_o,
    output logic [7:0]  done_fail_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [21:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    input  logic [31:0] wb_dat_i
);

    localparam int unsigned NCH  = 8;
    localparam int unsigned CHW  = 3;
    localparam int unsigned TMOW = 16;
    localparam int unsigned RTYW = 4;

    localparam logic [1:0] ST_OK  = 2'd0;
    localparam logic [1:0] ST_ERR = 2'd1;
    localparam logic [1:0] ST_RTY = 2'd2;
    localparam logic [1:0] ST_TMO = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_BUS, S_GAP, S_RESP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [NCH-1:0]    mask_q, mask_d;
    logic              c_we_q, c_we_d;
    logic [9:0]        c_adr_q, c_adr_d;
    logic [31:0]       c_dat_q, c_dat_d;
    logic [3:0]        c_sel_q, c_sel_d;
    logic [CHW-1:0]    chan_q, chan_d;
    logic [RTYW-1:0]   retry_q, retry_d;
    logic [TMOW-1:0]   tmo_q, tmo_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              cyc_q, cyc_d;
    logic              wb_we_q, wb_we_d;
    logic [21:0]       wb_adr_q, wb_adr_d;
    logic [31:0]       wb_dat_q, wb_dat_d;
    logic [3:0]        wb_sel_q, wb_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CHW-1:0]    rsp_chan_q, rsp_chan_d;
    logic [31:0]       rsp_dat_q, rsp_dat_d;
    logic [1:0]        rsp_status_q, rsp_status_d;
    logic              done_q, done_d;
    logic [NCH-1:0]    done_fail_q, done_fail_d;
    logic              fin;
    logic [1:0]        fin_status;
    logic [CHW-1:0]    next_chan;

    // Index of the lowest set bit of the remaining channel mask
    function automatic logic [CHW-1:0] lowest_chan(input logic [NCH-1:0] m);
        logic [CHW-1:0] c;
        c = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (m[i]) c = CHW'(i);
        end
        return c;
    endfunction

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        c_we_d       = c_we_q;
        c_adr_d      = c_adr_q;
        c_dat_d      = c_dat_q;
        c_sel_d      = c_sel_q;
        chan_d       = chan_q;
        retry_d      = retry_q;
        tmo_d        = tmo_q;
        cmd_ready_d  = cmd_ready_q;
        cyc_d        = cyc_q;
        wb_we_d      = wb_we_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        wb_sel_d     = wb_sel_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_chan_d   = rsp_chan_q;
        rsp_dat_d    = rsp_dat_q;
        rsp_status_d = rsp_status_q;
        done_d       = 1'b0;
        done_fail_d  = done_fail_q;
        fin          = 1'b0;
        fin_status   = ST_OK;
        next_chan    = lowest_chan(mask_q);

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_q) begin
                    mask_d      = cmd_chmask_i;
                    c_we_d      = cmd_we_i;
                    c_adr_d     = cmd_adr_i;
                    c_dat_d     = cmd_dat_i;
                    c_sel_d     = cmd_sel_i;
                    done_fail_d = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = S_SCAN;
                end
            end
            S_SCAN: begin
                retry_d = '0;
                if (mask_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    chan_d   = next_chan;
                    wb_adr_d = {9'b0, next_chan, c_adr_q};
                    wb_we_d  = c_we_q;
                    wb_dat_d = c_dat_q;
                    wb_sel_d = c_sel_q;
                    tmo_d    = '0;
                    cyc_d    = 1'b1;
                    state_d  = S_BUS;
                end
            end
            S_BUS: begin
                if (wb_err_i) begin
                    fin        = 1'b1;
                    fin_status = ST_ERR;
                end else if (wb_ack_i) begin
                    fin        = 1'b1;
                    fin_status = ST_OK;
                end else if (wb_rty_i) begin
                    if (retry_q < RTYW'(MAX_RETRY)) begin
                        retry_d = retry_q + RTYW'(1);
                        cyc_d   = 1'b0;
                        state_d = S_GAP;
                    end else begin
                        fin        = 1'b1;
                        fin_status = ST_RTY;
                    end
                end else if (tmo_q == TMOW'(TIMEOUT_CYCLES - 1)) begin
                    fin        = 1'b1;
                    fin_status = ST_TMO;
                end else begin
                    tmo_d = tmo_q + TMOW'(1);
                end
                if (fin) begin
                    cyc_d        = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_chan_d   = chan_q;
                    rsp_status_d = fin_status;
                    rsp_dat_d    = (fin_status == ST_OK && !c_we_q) ? wb_dat_i : '0;
                    if (fin_status != ST_OK) done_fail_d[chan_q] = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_GAP: begin
                tmo_d   = '0;
                cyc_d   = 1'b1;
                state_d = S_BUS;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d    = 1'b0;
                    mask_d[chan_q] = 1'b0;
                    state_d        = S_SCAN;
                end
            end
            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            c_we_q       <= 1'b0;
            c_adr_q      <= '0;
            c_dat_q      <= '0;
            c_sel_q      <= '0;
            chan_q       <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            cmd_ready_q  <= 1'b1;
            cyc_q        <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_adr_q     <= '0;
            wb_dat_q     <= '0;
            wb_sel_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_chan_q   <= '0;
            rsp_dat_q    <= '0;
            rsp_status_q <= '0;
            done_q       <= 1'b0;
            done_fail_q  <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            c_we_q       <= c_we_d;
            c_adr_q      <= c_adr_d;
            c_dat_q      <= c_dat_d;
            c_sel_q      <= c_sel_d;
            chan_q       <= chan_d;
            retry_q      <= retry_d;
            tmo_q        <= tmo_d;
            cmd_ready_q  <= cmd_ready_d;
            cyc_q        <= cyc_d;
            wb_we_q      <= wb_we_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            wb_sel_q     <= wb_sel_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_chan_q   <= rsp_chan_d;
            rsp_dat_q    <= rsp_dat_d;
            rsp_status_q <= rsp_status_d;
            done_q       <= done_d;
            done_fail_q  <= done_fail_d;
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_chan_o   = rsp_chan_q;
    assign rsp_dat_o    = rsp_dat_q;
    assign rsp_status_o = rsp_status_q;
    assign done_o       = done_q;
    assign done_fail_o  = done_fail_q;
    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = wb_we_q;
    assign wb_adr_o     = wb_adr_q;
    assign wb_dat_o     = wb_dat_q;
    assign wb_sel_o     = wb_sel_q;

endmodule

// File: tb/tb_trigger_chain_wb_sequencer.sv
// Bench for trigger_chain_wb_sequencer: scripted Wishbone target per channel,
// response scoreboard, and one task per scenario.
module tb_trigger_chain_wb_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_we_i;
    logic [9:0]  cmd_adr_i;
    logic [31:0] cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic [7:0]  cmd_chmask_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [2:0]  rsp_chan_o;
    logic [31:0] rsp_dat_o;
    logic [1:0]  rsp_status_o;
    logic        done_o;
    logic [7:0]  done_fail_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [21:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i, wb_rty_i;
    logic [31:0] wb_dat_i;

    trigger_chain_wb_sequencer #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
        .cmd_chmask_i(cmd_chmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_chan_o(rsp_chan_o),
        .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
        .done_o(done_o), .done_fail_o(done_fail_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i),
        .wb_dat_i(wb_dat_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    // Target script: rty count before the final answer; final 0=ack 1=err 2=silent 3=ack+err
    int          rty_n[8];
    int          rty_seen[8];
    int          fin_kind[8];
    logic [31:0] rdata[8];

    // Scoreboard and bus logs; response entry is {chan, dat, status}
    logic [36:0] exp_rsp[$];
    logic [36:0] obs_rsp[$];
    logic [7:0]  obs_done[$];
    int          obs_done_cyc[$];
    int          rise_cyc[$];
    int          fall_cyc[$];
    logic [21:0] bus_adr[$];
    logic        bus_we[$];
    logic [31:0] bus_dat[$];
    logic        cyc_prev = 1'b0;

    always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

    // Wishbone target: answers in the first cycle of each strobe
    initial begin
        wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
        forever begin
            @(posedge wb_clk_i);
            #1;
            wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
            if (wb_cyc_o && wb_stb_o) begin
                automatic int ch = int'(wb_adr_o[12:10]);
                if (rty_seen[ch] < rty_n[ch]) begin
                    wb_rty_i = 1'b1;
                    rty_seen[ch]++;
                end else begin
                    case (fin_kind[ch])
                        0: begin wb_ack_i = 1'b1; wb_dat_i = rdata[ch]; end
                        1: wb_err_i = 1'b1;
                        3: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = rdata[ch]; end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Output monitor, sampled on the falling edge
    always @(negedge wb_clk_i) begin
        if (rsp_valid_o && rsp_ready_i) obs_rsp.push_back({rsp_chan_o, rsp_dat_o, rsp_status_o});
        if (done_o) begin
            obs_done.push_back(done_fail_o);
            obs_done_cyc.push_back(cyc_cnt);
        end
        if (wb_cyc_o && !cyc_prev) begin
            rise_cyc.push_back(cyc_cnt);
            bus_adr.push_back(wb_adr_o);
            bus_we.push_back(wb_we_o);
            bus_dat.push_back(wb_dat_o);
        end
        if (!wb_cyc_o && cyc_prev) fall_cyc.push_back(cyc_cnt);
        cyc_prev = wb_cyc_o;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        exp_rsp.delete(); obs_rsp.delete(); obs_done.delete(); obs_done_cyc.delete();
        rise_cyc.delete(); fall_cyc.delete(); bus_adr.delete(); bus_we.delete(); bus_dat.delete();
        for (int i = 0; i < 8; i++) begin
            rty_n[i] = 0; rty_seen[i] = 0; fin_kind[i] = 0; rdata[i] = 32'h1000_0000 + i;
        end
    endtask

    // Drive one command and return the cycle index of the handshake (-1 if never accepted)
    task automatic send_cmd(input logic we, input logic [9:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic [7:0] mask, output int hs);
        @(posedge wb_clk_i); #1;
        cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel; cmd_chmask_i = mask;
        cmd_valid_i = 1'b1;
        hs = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge wb_clk_i);
            if (cmd_ready_o) begin hs = cyc_cnt; break; end
        end
        @(posedge wb_clk_i); #1;
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge wb_clk_i);
            if (obs_done.size() > 0) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge wb_clk_i);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, done_o, cmd_ready_o} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000001",
                     {wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, done_o, cmd_ready_o});
        end
        n_checks++;
        if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 58'd0) begin
            n_fail++; $display("FAIL reset_bus: got %h expected 0", {wb_adr_o, wb_dat_o, wb_sel_o});
        end
        n_checks++;
        if ({rsp_chan_o, rsp_dat_o, rsp_status_o, done_fail_o} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_chan_o, rsp_dat_o, rsp_status_o, done_fail_o});
        end
    endtask

    task automatic test_write_broadcast();
        int hs; bit ok; logic [36:0] e, o;
        clear_logs();
        for (int ch = 0; ch < 8; ch++) exp_rsp.push_back({3'(ch), 32'd0, 2'd0});
        send_cmd(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 8'hFF, hs);
        wait_done(400, ok);
        n_checks++;
        if (hs < 0 || !ok) begin n_fail++; $display("FAIL bcast_done: got hs=%0d ok=%0d expected accepted and done", hs, ok); end
        n_checks++;
        if (rise_cyc.size() != 8) begin n_fail++; $display("FAIL bcast_ncyc: got %0d expected 8", rise_cyc.size()); end
        n_checks++;
        if (rise_cyc.size() > 0 && rise_cyc[0] != hs + 2) begin
            n_fail++; $display("FAIL bcast_first_cyc: got cycle %0d expected %0d", rise_cyc[0], hs + 2);
        end
        for (int i = 0; i < bus_adr.size() && i < 8; i++) begin
            n_checks++;
            if ({bus_we[i], bus_adr[i], bus_dat[i]} !== {1'b1, 22'(i * 'h400 + 'h010), 32'hDEADBEEF}) begin
                n_fail++;
                $display("FAIL bcast_bus[%0d]: got we=%b adr=%h dat=%h expected we=1 adr=%h dat=deadbeef",
                         i, bus_we[i], bus_adr[i], bus_dat[i], 22'(i * 'h400 + 'h010));
            end
        end
        while (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            n_checks++;
            if (obs_rsp.size() == 0) begin n_fail++; $display("FAIL bcast_rsp: got none expected %h", e); end
            else begin
                o = obs_rsp.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL bcast_rsp: got %h expected %h", o, e); end
            end
        end
        n_checks++;
        if (obs_rsp.size() != 0 || obs_done.size() != 1 || obs_done[0] !== 8'h00) begin
            n_fail++; $display("FAIL bcast_fail_mask: got extra=%0d ndone=%0d expected 0 extra, one done with 00",
                               obs_rsp.size(), obs_done.size());
        end
    endtask

    task automatic test_sparse_read();
        int hs; bit ok; logic [36:0] e, o;
        clear_logs();
        rdata[2] = 32'h0000_1234; rdata[5] = 32'h0000_ABCD;
        exp_rsp.push_back({3'd2, 32'h1234, 2'd0});
        exp_rsp.push_back({3'd5, 32'hABCD, 2'd0});
        send_cmd(1'b0, 10'h0C4, 32'h0, 4'h3, 8'h24, hs);
        wait_done(200, ok);
        n_checks++;
        if (hs < 0 || !ok) begin n_fail++; $display("FAIL sparse_done: got hs=%0d ok=%0d expected accepted and done", hs, ok); end
        n_checks++;
        if (bus_adr.size() != 2 || bus_adr[0] !== 22'h08C4 || bus_adr[1] !== 22'h14C4 || bus_we[0] !== 1'b0) begin
            n_fail++; $display("FAIL sparse_adr: got n=%0d adr0=%h expected 2 reads at 08c4,14c4",
                               bus_adr.size(), bus_adr.size() > 0 ? bus_adr[0] : 22'h0);
        end
        while (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            n_checks++;
            if (obs_rsp.size() == 0) begin n_fail++; $display("FAIL sparse_rsp: got none expected %h", e); end
            else begin
                o = obs_rsp.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL sparse_rsp: got %h expected %h", o, e); end
            end
        end
    endtask

    task automatic test_retry();
        int hs; bit ok; logic [36:0] e, o;
        for (int pass = 0; pass < 2; pass++) begin
            clear_logs();
            rty_n[3] = 3 + pass; rdata[3] = 32'h5555_AAAA;
            exp_rsp.push_back(pass == 0 ? {3'd3, 32'h5555_AAAA, 2'd0} : {3'd3, 32'd0, 2'd2});
            send_cmd(1'b0, 10'h3FC, 32'h0, 4'hF, 8'h08, hs);
            wait_done(200, ok);
            n_checks++;
            if (hs < 0 || !ok) begin n_fail++; $display("FAIL retry_done[%0d]: got hs=%0d ok=%0d expected done", pass, hs, ok); end
            n_checks++;
            if (rise_cyc.size() != 4) begin n_fail++; $display("FAIL retry_nstb[%0d]: got %0d expected 4", pass, rise_cyc.size()); end
            for (int i = 0; i + 1 < rise_cyc.size() && i < fall_cyc.size(); i++) begin
                n_checks++;
                if (rise_cyc[i + 1] - fall_cyc[i] != 1) begin
                    n_fail++; $display("FAIL retry_gap[%0d]: got %0d cycles expected 1", i, rise_cyc[i + 1] - fall_cyc[i]);
                end
            end
            while (exp_rsp.size() > 0) begin
                e = exp_rsp.pop_front();
                n_checks++;
                if (obs_rsp.size() == 0) begin n_fail++; $display("FAIL retry_rsp: got none expected %h", e); end
                else begin
                    o = obs_rsp.pop_front();
                    if (o !== e) begin n_fail++; $display("FAIL retry_rsp: got %h expected %h", o, e); end
                end
            end
            n_checks++;
            if (obs_done.size() != 1 || obs_done[0] !== (pass == 0 ? 8'h00 : 8'h08)) begin
                n_fail++; $display("FAIL retry_fail_mask[%0d]: got %h expected %h", pass,
                                   obs_done.size() > 0 ? obs_done[0] : 8'hxx, pass == 0 ? 8'h00 : 8'h08);
            end
        end
    endtask

    task automatic test_timeout_priority();
        int hs; bit ok; logic [36:0] e, o;
        clear_logs();
        fin_kind[0] = 2; fin_kind[1] = 3; rdata[1] = 32'hCAFE_F00D;
        exp_rsp.push_back({3'd0, 32'd0, 2'd3});
        exp_rsp.push_back({3'd1, 32'd0, 2'd1});
        send_cmd(1'b0, 10'h020, 32'h0, 4'hF, 8'h03, hs);
        wait_done(300, ok);
        n_checks++;
        if (hs < 0 || !ok) begin n_fail++; $display("FAIL tmo_done: got hs=%0d ok=%0d expected done", hs, ok); end
        n_checks++;
        if (rise_cyc.size() < 1 || fall_cyc.size() < 1 || fall_cyc[0] - rise_cyc[0] != 16) begin
            n_fail++; $display("FAIL tmo_len: got %0d cycles expected 16",
                               (rise_cyc.size() > 0 && fall_cyc.size() > 0) ? fall_cyc[0] - rise_cyc[0] : -1);
        end
        while (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            n_checks++;
            if (obs_rsp.size() == 0) begin n_fail++; $display("FAIL tmo_rsp: got none expected %h", e); end
            else begin
                o = obs_rsp.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL tmo_rsp: got %h expected %h", o, e); end
            end
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] !== 8'h03) begin
            n_fail++; $display("FAIL tmo_fail_mask: got %h expected 03", obs_done.size() > 0 ? obs_done[0] : 8'hxx);
        end
    endtask

    task automatic test_backpressure_empty();
        int hs; bit ok; bit seen; bit stable; logic [36:0] snap, e, o; int nrise;
        clear_logs();
        rdata[0] = 32'h0A0A_0A0A; rdata[1] = 32'h0B0B_0B0B;
        exp_rsp.push_back({3'd0, 32'h0A0A_0A0A, 2'd0});
        exp_rsp.push_back({3'd1, 32'h0B0B_0B0B, 2'd0});
        rsp_ready_i = 1'b0;
        send_cmd(1'b0, 10'h100, 32'h0, 4'hF, 8'h03, hs);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge wb_clk_i);
            if (rsp_valid_o) begin seen = 1'b1; break; end
        end
        snap = {rsp_chan_o, rsp_dat_o, rsp_status_o};
        nrise = rise_cyc.size();
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            if (!rsp_valid_o || {rsp_chan_o, rsp_dat_o, rsp_status_o} !== snap || wb_cyc_o) stable = 1'b0;
        end
        n_checks++;
        if (!seen || !stable) begin n_fail++; $display("FAIL bp_stable: got seen=%0d stable=%0d expected 1 1", seen, stable); end
        n_checks++;
        if (rise_cyc.size() != nrise || nrise != 1) begin
            n_fail++; $display("FAIL bp_no_new_cyc: got %0d strobes expected 1", rise_cyc.size());
        end
        @(posedge wb_clk_i); #1;
        rsp_ready_i = 1'b1;
        wait_done(200, ok);
        n_checks++;
        if (!ok || obs_done[0] !== 8'h00) begin n_fail++; $display("FAIL bp_done: got ok=%0d expected done with 00", ok); end
        while (exp_rsp.size() > 0) begin
            e = exp_rsp.pop_front();
            n_checks++;
            if (obs_rsp.size() == 0) begin n_fail++; $display("FAIL bp_rsp: got none expected %h", e); end
            else begin
                o = obs_rsp.pop_front();
                if (o !== e) begin n_fail++; $display("FAIL bp_rsp: got %h expected %h", o, e); end
            end
        end
        // Empty mask
        clear_logs();
        send_cmd(1'b1, 10'h000, 32'h1, 4'hF, 8'h00, hs);
        wait_done(20, ok);
        n_checks++;
        if (!ok || obs_done_cyc[0] != hs + 2) begin
            n_fail++; $display("FAIL empty_done_time: got ok=%0d cycle %0d expected cycle %0d", ok,
                               obs_done_cyc.size() > 0 ? obs_done_cyc[0] : -1, hs + 2);
        end
        n_checks++;
        if (rise_cyc.size() != 0 || obs_rsp.size() != 0 || obs_done.size() != 1 || obs_done[0] !== 8'h00) begin
            n_fail++; $display("FAIL empty_activity: got strobes=%0d rsps=%0d expected 0 0 with fail mask 00",
                               rise_cyc.size(), obs_rsp.size());
        end
    endtask

    task automatic test_reset_mid_bus();
        int hs; bit ok; bit seen; logic [36:0] o;
        clear_logs();
        fin_kind[4] = 2;
        send_cmd(1'b1, 10'h044, 32'h1111_2222, 4'hF, 8'h10, hs);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge wb_clk_i);
            if (wb_cyc_o) begin seen = 1'b1; break; end
        end
        #2;
        wb_rst_n_i = 1'b0;
        #1;
        n_checks++;
        if (!seen || {wb_cyc_o, wb_stb_o, rsp_valid_o, done_o, cmd_ready_o} !== 5'b00001) begin
            n_fail++; $display("FAIL rst_mid: got seen=%0d ctrl=%b expected 1 00001", seen,
                               {wb_cyc_o, wb_stb_o, rsp_valid_o, done_o, cmd_ready_o});
        end
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        clear_logs();
        rdata[4] = 32'h4444_0004;
        send_cmd(1'b0, 10'h044, 32'h0, 4'hF, 8'h10, hs);
        wait_done(100, ok);
        n_checks++;
        if (hs < 0 || !ok || obs_done[0] !== 8'h00 || rise_cyc.size() != 1) begin
            n_fail++; $display("FAIL rst_after: got hs=%0d ok=%0d strobes=%0d expected normal single read",
                               hs, ok, rise_cyc.size());
        end
        n_checks++;
        if (obs_rsp.size() != 1) begin n_fail++; $display("FAIL rst_after_rsp: got %0d rsps expected 1", obs_rsp.size()); end
        else begin
            o = obs_rsp.pop_front();
            if (o !== {3'd4, 32'h4444_0004, 2'd0}) begin
                n_fail++; $display("FAIL rst_after_rsp: got %h expected %h", o, {3'd4, 32'h4444_0004, 2'd0});
            end
        end
    endtask

    initial begin
        wb_rst_n_i = 1'b0;
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_adr_i = '0; cmd_dat_i = '0;
        cmd_sel_i = '0; cmd_chmask_i = '0; rsp_ready_i = 1'b1;
        clear_logs();
        repeat (3) @(negedge wb_clk_i);
        test_reset();
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
        test_write_broadcast();
        test_sparse_read();
        test_retry();
        test_timeout_priority();
        test_backpressure_empty();
        test_reset_mid_bus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
